// File: rtl/mic1_io_pkg.sv
// Shared types and defaults for the MIC-1 push-button front end.
// The channel state enum is visible at the top level for debug and checkers.
package mic1_io_pkg;

   typedef enum logic [1:0] {
      REL        = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } btn_state_t;

   localparam int DEBOUNCE_MAX_DEF = 511;
   localparam int LONG_MAX_DEF     = 6000000;

   // Counter width able to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce FSM with its counter,
// registered press/release strobes and a one-shot long-press strobe.
module btn_channel
   import mic1_io_pkg::*;
#(
   parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
   parameter int LONG_MAX     = LONG_MAX_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       pin_i,
   output logic       level_o,
   output logic       press_o,
   output logic       release_o,
   output logic       long_o,
   output btn_state_t state_o
);

   localparam int DW = cnt_width(DEBOUNCE_MAX);
   localparam int HW = cnt_width(LONG_MAX);

   logic          s0_q;
   logic          s1_q;
   btn_state_t    state_q, state_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         state_q   <= REL;
         dcnt_q    <= '0;
         hcnt_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         s0_q      <= pin_i;
         s1_q      <= s0_q;
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         hcnt_q    <= hcnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   // dcnt counts consecutive cycles on which s1 disagrees with the debounced level.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         REL: begin
            if (s1_q) begin
               state_d = PRESS_WAIT;
               dcnt_d  = DW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!s1_q) begin
               state_d = REL;
            end else if (dcnt_q == DW'(DEBOUNCE_MAX)) begin
               state_d = HELD;
               press_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         HELD: begin
            if (!s1_q) begin
               state_d = REL_WAIT;
               dcnt_d  = DW'(1);
            end
         end
         REL_WAIT: begin
            if (s1_q) begin
               state_d = HELD;
            end else if (dcnt_q == DW'(DEBOUNCE_MAX)) begin
               state_d   = REL;
               release_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = REL;
      endcase
   end

   // hcnt saturates at LONG_MAX so the strobe fires only on the way up.
   always_comb begin
      hcnt_d = '0;
      long_d = 1'b0;
      if (state_q == HELD || state_q == REL_WAIT) begin
         hcnt_d = hcnt_q;
         if (hcnt_q != HW'(LONG_MAX)) begin
            hcnt_d = hcnt_q + HW'(1);
         end
         long_d = (hcnt_q == HW'(LONG_MAX - 1));
      end
   end

   assign level_o   = (state_q == HELD) || (state_q == REL_WAIT);
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the MIC-1 run/step/stop control: NUM_BTN
// independent debounced channels with press, release and long-press strobes.
module button_conditioner
   import mic1_io_pkg::*;
#(
   parameter int NUM_BTN      = 3,
   parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
   parameter int LONG_MAX     = LONG_MAX_DEF,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic       [NUM_BTN-1:0] btn_raw_i,
   output logic       [NUM_BTN-1:0] level_o,
   output logic       [NUM_BTN-1:0] press_o,
   output logic       [NUM_BTN-1:0] release_o,
   output logic       [NUM_BTN-1:0] long_o,
   output btn_state_t [NUM_BTN-1:0] dbg_state_o
);

   if (DEBOUNCE_MAX < 1) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_MAX must be >= 1");
   end
   if (LONG_MAX < 1) begin : g_bad_long
      $error("button_conditioner: LONG_MAX must be >= 1");
   end

   // Pressed is always 1 from here on, whatever the board wiring.
   logic [NUM_BTN-1:0] pin_pressed;
   assign pin_pressed = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_channel #(
         .DEBOUNCE_MAX(DEBOUNCE_MAX),
         .LONG_MAX    (LONG_MAX)
      ) u_chan (
         .clk_i    (clk_i),
         .reset_i  (reset_i),
         .pin_i    (pin_pressed[i]),
         .level_o  (level_o[i]),
         .press_o  (press_o[i]),
         .release_o(release_o[i]),
         .long_o   (long_o[i]),
         .state_o  (dbg_state_o[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a behavioural per-channel model
// compared every cycle, plus hand-computed timing checks.
module tb_button_conditioner;
   import mic1_io_pkg::*;

   localparam int NB  = 3;
   localparam int DEB = 3;
   localparam int LNG = 10;

   logic                clk;
   logic                reset;
   logic [NB-1:0]       btn_raw;
   logic [NB-1:0]       level;
   logic [NB-1:0]       press;
   logic [NB-1:0]       rel;
   logic [NB-1:0]       lng;
   btn_state_t [NB-1:0] dbg_state;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   button_conditioner #(
      .NUM_BTN     (NB),
      .DEBOUNCE_MAX(DEB),
      .LONG_MAX    (LNG),
      .ACTIVE_LOW  (1'b0)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .btn_raw_i  (btn_raw),
      .level_o    (level),
      .press_o    (press),
      .release_o  (rel),
      .long_o     (lng),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: level flips once the synchronised pin has disagreed
   // with it for DEB+1 consecutive cycles; long fires on the LNG-th cycle of level=1.
   logic [NB-1:0] m_s0 = '0, m_s1 = '0, m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
   int m_run  [NB];
   int m_held [NB];

   always @(posedge clk) begin
      for (int c = 0; c < NB; c++) begin
         if (reset) begin
            m_s0[c] <= 1'b0; m_s1[c] <= 1'b0; m_level[c] <= 1'b0;
            m_press[c] <= 1'b0; m_rel[c] <= 1'b0; m_long[c] <= 1'b0;
            m_run[c] <= 0; m_held[c] <= 0;
         end else begin
            m_s0[c]    <= btn_raw[c];
            m_s1[c]    <= m_s0[c];
            m_press[c] <= 1'b0;
            m_rel[c]   <= 1'b0;
            if (m_s1[c] != m_level[c]) begin
               if (m_run[c] + 1 == DEB + 1) begin
                  m_level[c] <= m_s1[c];
                  m_press[c] <= m_s1[c];
                  m_rel[c]   <= ~m_s1[c];
                  m_run[c]   <= 0;
               end else begin
                  m_run[c] <= m_run[c] + 1;
               end
            end else begin
               m_run[c] <= 0;
            end
            if (m_level[c]) begin
               m_held[c] <= m_held[c] + 1;
               m_long[c] <= (m_held[c] + 1 == LNG);
            end else begin
               m_held[c] <= 0;
               m_long[c] <= 1'b0;
            end
         end
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_level",   32'(level), 32'(m_level));
         check("model_press",   32'(press), 32'(m_press));
         check("model_release", 32'(rel),   32'(m_rel));
         check("model_long",    32'(lng),   32'(m_long));
         check("press_and_release", 32'(press & rel), 32'd0);
      end
   end

   // driver
   int pc, lc, ln, rc, rn, pn;
   bit seen;

   initial begin
      reset   = 1'b1;
      btn_raw = 3'b111;
      @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);

      // 1: reset with all pins high, then a simultaneous press
      check("rst_level",   32'(level), 32'd0);
      check("rst_press",   32'(press), 32'd0);
      check("rst_release", 32'(rel),   32'd0);
      check("rst_long",    32'(lng),   32'd0);
      check("rst_state",   32'(dbg_state), 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k < 6)  check("t1_press_early", 32'(press), 32'd0);
         if (k == 6) check("t1_press_at6", 32'(press), 32'b111);
         if (k == 7) begin
            check("t1_press_gone", 32'(press), 32'd0);
            check("t1_level",      32'(level), 32'b111);
         end
      end
      btn_raw = 3'b000;
      repeat (12) @(negedge clk);
      check("t1_released", 32'(level), 32'd0);

      // 2: 3-cycle glitch on channel 0
      seen = 1'b0;
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 3) btn_raw[0] = 1'b0;
         seen = seen | press[0] | level[0];
      end
      check("t2_glitch", 32'(seen), 32'd0);

      // 3: long hold on channel 1
      pc = 0; lc = 0; ln = 0;
      btn_raw[1] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (press[1]) pc = k;
         if (lng[1]) begin lc = k; ln++; end
      end
      check("t3_press_at", 32'(pc), 32'd6);
      check("t3_long_at",  32'(lc), 32'd16);
      check("t3_long_cnt", 32'(ln), 32'd1);
      rc = 0;
      btn_raw[1] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (rel[1]) rc = k;
      end
      check("t3_release_at", 32'(rc), 32'd6);

      // 4: bounce on channel 2, then steady high
      pc = 0; pn = 0; rn = 0;
      btn_raw[2] = 1'b1; @(negedge clk);
      btn_raw[2] = 1'b0; @(negedge clk);
      btn_raw[2] = 1'b1; @(negedge clk);
      btn_raw[2] = 1'b0; @(negedge clk);
      btn_raw[2] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (press[2]) begin pc = k; pn++; end
         if (rel[2]) rn++;
      end
      check("t4_press_at",   32'(pc), 32'd6);
      check("t4_press_cnt",  32'(pn), 32'd1);
      check("t4_no_release", 32'(rn), 32'd0);
      btn_raw[2] = 1'b0;
      repeat (12) @(negedge clk);

      // 5: short hold on channel 0, no long strobe
      pc = 0; ln = 0; rc = 0; rn = 0;
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (press[0]) pc = k;
         if (lng[0]) ln++;
      end
      btn_raw[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rel[0]) begin rc = k; rn++; end
         if (lng[0]) ln++;
      end
      check("t5_press_at",    32'(pc), 32'd6);
      check("t5_no_long",     32'(ln), 32'd0);
      check("t5_release_cnt", 32'(rn), 32'd1);
      check("t5_release_at",  32'(rc), 32'd6);

      // 6: reset pulse while channel 1 is held
      pc = 0;
      btn_raw[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (press[1]) pc = k;
      end
      check("t6_first_press", 32'(pc), 32'd6);
      repeat (5) @(negedge clk);
      check("t6_level_before", 32'(level), 32'b010);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_level_dropped", 32'(level), 32'd0);
      pc = 0; lc = 0; ln = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (press[1]) pc = k;
         if (lng[1]) begin lc = k; ln++; end
      end
      check("t6_repress_at", 32'(pc), 32'd6);
      check("t6_long_at",    32'(lc), 32'd16);
      check("t6_long_cnt",   32'(ln), 32'd1);
      btn_raw[1] = 1'b0;
      repeat (12) @(negedge clk);

      // report
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
